// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - three-port arbiter/sequencer for a fixed-latency synchronous memory
// Optional starvation guard enabled by defining STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int MEM_LAT  = 2,
    parameter int MAX_WAIT = 8
) (
    input  logic                  clk1,
    input  logic                  rst,
    input  logic                  halted,
    input  logic [2:0]            req,
    input  logic [2:0]            we,
    input  logic [3*ADDR_W-1:0]   addr,
    input  logic [3*DATA_W-1:0]   wdata,
    output logic [2:0]            gnt,
    output logic [2:0]            done,
    output logic [DATA_W-1:0]     rdata,
    output logic                  busy,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

    logic [1:0]        state_q,     state_d;
    logic [1:0]        owner_q,     owner_d;
    logic              wr_q,        wr_d;
    logic [3:0]        cnt_q,       cnt_d;
    logic [2:0]        gnt_q,       gnt_d;
    logic [2:0]        done_q,      done_d;
    logic [DATA_W-1:0] rdata_q,     rdata_d;
    logic              busy_q,      busy_d;
    logic              mem_en_q,    mem_en_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [2:0]        elig;
    logic [1:0]        sel;

`ifdef STARVE_GUARD_EN
    localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);
    logic [2:0][3:0]   age_q, age_d;
`endif

    always_comb begin
        // Fetch is masked while the core is halted; data beats fetch beats debug.
        elig = req & {2'b11, ~halted};
        if (elig[1]) begin
            sel = 2'd1;
        end else if (elig[0]) begin
            sel = 2'd0;
        end else begin
            sel = 2'd2;
        end
`ifdef STARVE_GUARD_EN
        // Descending scan so the lowest aged id is the one that sticks.
        for (int k = 2; k >= 0; k--) begin
            if (elig[k] && (age_q[k] >= MAX_WAIT_L)) begin
                sel = 2'(k);
            end
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        wr_d        = wr_q;
        cnt_d       = cnt_q;
        gnt_d       = 3'b000;
        done_d      = 3'b000;
        rdata_d     = rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (elig != 3'b000) begin
                    owner_d     = sel;
                    wr_d        = (sel != 2'd0) && we[sel];
                    mem_addr_d  = addr[sel*ADDR_W +: ADDR_W];
                    mem_wdata_d = wdata[sel*DATA_W +: DATA_W];
                    gnt_d       = 3'b001 << sel;
                    mem_en_d    = 1'b1;
                    mem_we_d    = (sel != 2'd0) && we[sel];
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = wr_q ? '0 : mem_rdata;
                    done_d  = 3'b001 << owner_q;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

`ifdef STARVE_GUARD_EN
    // The current owner does not age while its own access is in flight.
    always_comb begin
        age_d = age_q;
        for (int k = 0; k < 3; k++) begin
            if (gnt_d[k]) begin
                age_d[k] = 4'd0;
            end else if (elig[k] && !((state_q != S_IDLE) && (owner_q == 2'(k)))
                         && (age_q[k] != 4'hF)) begin
                age_d[k] = age_q[k] + 4'd1;
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`endif

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_q     <= 2'd0;
            wr_q        <= 1'b0;
            cnt_q       <= 4'd0;
            gnt_q       <= 3'b000;
            done_q      <= 3'b000;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            wr_q        <= wr_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic          clk1 = 1'b0;
    logic          rst = 1'b1;
    logic          halted = 1'b0;
    logic [2:0]    req = 3'b000;
    logic [2:0]    we = 3'b000;
    logic [3*AW-1:0] addr = '0;
    logic [3*DW-1:0] wdata = '0;
    logic [2:0]    gnt, done;
    logic [DW-1:0] rdata;
    logic          busy, mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic [2:0]    r1_req = 3'b000;
    logic [3*AW-1:0] r1_addr = '0;
    logic [2:0]    r1_gnt, r1_done;
    logic [DW-1:0] r1_rdata;
    logic          r1_busy, r1_mem_en, r1_mem_we;
    logic [AW-1:0] r1_mem_addr;
    logic [DW-1:0] r1_mem_wdata, r1_mem_rdata;

    logic [DW-1:0] mem [0:1023];
    logic [DW-1:0] pipe0, pipe1, r1_pipe0;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk1 = ~clk1;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .MAX_WAIT(8)) dut (
        .clk1(clk1), .rst(rst), .halted(halted), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .MAX_WAIT(8)) dut1 (
        .clk1(clk1), .rst(rst), .halted(1'b0), .req(r1_req), .we(3'b000), .addr(r1_addr),
        .wdata('0), .gnt(r1_gnt), .done(r1_done), .rdata(r1_rdata), .busy(r1_busy),
        .mem_en(r1_mem_en), .mem_we(r1_mem_we), .mem_addr(r1_mem_addr),
        .mem_wdata(r1_mem_wdata), .mem_rdata(r1_mem_rdata)
    );

    // Synchronous memories: data appears LAT (or 1) cycles after the strobe cycle.
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] <= 32'h1000_0000 + i;
        mem[0] <= 32'hA0A0_0000;
        mem[3] <= 32'h3333_0003;
        mem[5] <= 32'hDEAD_BEEF;
    end

    always @(posedge clk1) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            pipe0 <= mem[mem_addr];
        end
        pipe1 <= pipe0;
        if (r1_mem_en) r1_pipe0 <= mem[r1_mem_addr];
    end
    assign mem_rdata    = pipe1;
    assign r1_mem_rdata = r1_pipe0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Schedule-based model: an accepted request at idle cycle c occupies the port
    // until c+LAT+3, grants at c+1 and completes at c+LAT+2.
    logic          on = 1'b0;
    logic [2:0]    e_gnt, e_done;
    logic          e_busy, e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rdata;
    int            cyc = 0;
    int            m_idle_at, m_start, m_owner;
    logic [DW-1:0] m_rd;
    int            age [3];

    initial begin
        forever begin
            int c, n, win;
            logic [2:0] elig;
            logic wr;
            @(posedge clk1);
            c = cyc;
            n = c + 1;
            cyc = n;
            if (rst) begin
                on = 1'b1;
                e_gnt = 0; e_done = 0; e_busy = 0; e_en = 0; e_we = 0;
                e_addr = 0; e_wdata = 0; e_rdata = 0;
                m_idle_at = n; m_owner = 0; m_start = -100;
                for (int k = 0; k < 3; k++) age[k] = 0;
            end else if (on) begin
                e_gnt = 0; e_done = 0; e_en = 0; e_we = 0;
                elig = req & {2'b11, ~halted};
                if (c == m_idle_at) begin
                    if (elig != 3'b000) begin
                        win = -1;
`ifdef STARVE_GUARD_EN
                        for (int k = 0; k < 3; k++)
                            if (win < 0 && elig[k] && age[k] >= 8) win = k;
`endif
                        if (win < 0) win = elig[1] ? 1 : (elig[0] ? 0 : 2);
                        for (int k = 0; k < 3; k++) begin
                            if (k == win) age[k] = 0;
                            else if (elig[k] && age[k] < 15) age[k]++;
                        end
                        wr = (win != 0) && we[win];
                        m_owner = win; m_start = c; m_idle_at = c + LAT + 3;
                        e_gnt[win] = 1'b1; e_en = 1'b1; e_we = wr;
                        e_addr = addr[win*AW +: AW];
                        e_wdata = wdata[win*DW +: DW];
                        m_rd = wr ? 32'h0 : mem[e_addr];
                    end else begin
                        m_idle_at = n;
                    end
                end else begin
                    for (int k = 0; k < 3; k++)
                        if (elig[k] && k != m_owner && age[k] < 15) age[k]++;
                    if (n == m_start + LAT + 2) begin
                        e_done[m_owner] = 1'b1;
                        e_rdata = m_rd;
                    end
                end
                e_busy = (n < m_idle_at);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk1);
            if (on) begin
                chk("m_gnt", 32'(gnt), 32'(e_gnt));
                chk("m_done", 32'(done), 32'(e_done));
                chk("m_busy", 32'(busy), 32'(e_busy));
                chk("m_mem_en", 32'(mem_en), 32'(e_en));
                chk("m_mem_we", 32'(mem_we), 32'(e_we));
                chk("m_mem_addr", 32'(mem_addr), 32'(e_addr));
                chk("m_mem_wdata", mem_wdata, e_wdata);
                chk("m_rdata", rdata, e_rdata);
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk1);
    endtask

    // Called at a negedge; the request becomes visible in cycle 0.
    task automatic read_check(input int k, input logic [AW-1:0] a, input logic [DW-1:0] v);
        req[k] = 1'b1;
        we[k] = 1'b0;
        addr[k*AW +: AW] = a;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk1);
            if (i == 1) begin
                chk("rd_gnt", 32'(gnt), 32'(3'(3'b001 << k)));
                chk("rd_mem_en", 32'(mem_en), 32'd1);
                chk("rd_mem_addr", 32'(mem_addr), 32'(a));
            end
            if (i == 4) begin
                chk("rd_done", 32'(done), 32'(3'(3'b001 << k)));
                chk("rd_rdata", rdata, v);
                req[k] = 1'b0;
            end
            if (i == 5) chk("rd_busy_after", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int first_dbg;
        logic seen_g, seen_e, seen_b, seen_d;
        logic drained;

        @(negedge clk1);
        @(negedge clk1);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        @(negedge clk1);
        rst = 1'b0;
        idle(2);

        read_check(1, 10'h005, 32'hDEAD_BEEF);
        idle(2);

        // Data write and fetch arrive together.
        req = 3'b011; we = 3'b010;
        addr[0*AW +: AW] = 10'h000; addr[1*AW +: AW] = 10'h009;
        wdata[1*DW +: DW] = 32'h0000_0012;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk1);
            if (i == 1) begin
                chk("wr_gnt", 32'(gnt), 32'h2);
                chk("wr_mem_we", 32'(mem_we), 32'd1);
                chk("wr_mem_addr", 32'(mem_addr), 32'h9);
                chk("wr_mem_wdata", mem_wdata, 32'h12);
            end
            if (i == 4) begin
                chk("wr_done", 32'(done), 32'h2);
                chk("wr_rdata", rdata, 32'h0);
                req[1] = 1'b0; we[1] = 1'b0;
            end
            if (i == 6) chk("if_gnt", 32'(gnt), 32'h1);
            if (i == 9) begin
                chk("if_done", 32'(done), 32'h1);
                chk("if_rdata", rdata, 32'hA0A0_0000);
                req[0] = 1'b0;
            end
        end
        chk("wr_mem9", mem[9], 32'h12);
        idle(2);

        // Halted core: fetch must wait.
        halted = 1'b1; req = 3'b001; addr[0*AW +: AW] = 10'h001;
        seen_g = 0; seen_e = 0; seen_b = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk1);
            seen_g |= (gnt != 0); seen_e |= mem_en; seen_b |= busy;
        end
        chk("halt_gnt", 32'(seen_g), 32'd0);
        chk("halt_mem_en", 32'(seen_e), 32'd0);
        chk("halt_busy", 32'(seen_b), 32'd0);
        halted = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk1);
            if (i == 1) chk("unhalt_gnt", 32'(gnt), 32'h1);
            if (i == 4) begin
                chk("unhalt_rdata", rdata, 32'h1000_0001);
                req = 3'b000;
            end
        end
        idle(2);

        // Continuous data traffic with a debug request waiting.
        req = 3'b110; we = 3'b000;
        addr[1*AW +: AW] = 10'h002; addr[2*AW +: AW] = 10'h004;
        first_dbg = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk1);
            if (gnt[2] && first_dbg < 0) first_dbg = i;
        end
`ifdef STARVE_GUARD_EN
        chk("starve_dbg_first_gnt", 32'(first_dbg), 32'd11);
`else
        chk("starve_dbg_never", 32'(first_dbg), 32'hFFFF_FFFF);
`endif
        drained = 1'b0;
        for (int i = 0; i < 20 && !drained; i++) begin
            @(negedge clk1);
            if (done != 0) begin
                req = 3'b000;
                drained = 1'b1;
            end
        end
        chk("starve_drain", 32'(drained), 32'd1);
        idle(3);

        // Reset while a data read is waiting on memory.
        req = 3'b010; addr[1*AW +: AW] = 10'h005;
        idle(2);
        rst = 1'b1; req = 3'b000;
        @(negedge clk1);
        chk("mid_rst_outs", {gnt, done, busy, mem_en, mem_we, 6'b0, mem_addr, 8'b0},
            32'h0);
        chk("mid_rst_rdata", rdata, 32'h0);
        chk("mid_rst_wdata", mem_wdata, 32'h0);
        rst = 1'b0;
        seen_d = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk1);
            seen_d |= (done != 0);
        end
        chk("mid_rst_no_done", 32'(seen_d), 32'd0);
        read_check(1, 10'h005, 32'hDEAD_BEEF);
        idle(2);

        // Single-cycle memory latency instance.
        r1_req = 3'b010; r1_addr[1*AW +: AW] = 10'h003;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk1);
            chk("lat1_gnt", 32'(r1_gnt), (i == 1) ? 32'h2 : 32'h0);
            chk("lat1_done", 32'(r1_done), (i == 3) ? 32'h2 : 32'h0);
            if (i == 3) begin
                chk("lat1_rdata", r1_rdata, 32'h3333_0003);
                r1_req = 3'b000;
            end
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
